// File: rtl/rx_ctrl_gen.sv
// Serial-receive controller: shifts in LSB-first words (optional even parity),
// writes each good word to RAM at a running address, then waits for restart.
module rx_ctrl_gen #(
  parameter int DATA_W    = 8,
  parameter int ADR_W     = 2,
  parameter int NUM_WORDS = 4,
  parameter int PARITY_EN = 0
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              Tx_vld,
  input  logic              Tx_data,
  input  logic              restart,
  output logic              Rx_ready,
  output logic              write,
  output logic              inc,
  output logic [ADR_W-1:0]  adr,
  output logic [DATA_W-1:0] wdata,
  output logic              Rx_finish,
  output logic              par_err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SHIFT  = 3'd1,
    PAR    = 3'd2,
    WRITE  = 3'd3,
    INC    = 3'd4,
    FINISH = 3'd5
  } state_t;

  // Counter holds the value DATA_W itself so the last shift never wraps.
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [ADR_W-1:0] LAST_ADR = ADR_W'(NUM_WORDS - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] bcnt;
  logic             last_bit, last_adr, par_ok;

  assign last_bit = (bcnt == LAST_BIT);
  assign last_adr = (adr == LAST_ADR);
  // Even parity: data bits plus parity bit must XOR to zero.
  assign par_ok   = ~(^wdata ^ Tx_data);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    Rx_ready  = 1'b0;
    write     = 1'b0;
    inc       = 1'b0;
    Rx_finish = 1'b0;
    case (state)
      IDLE: begin
        Rx_ready = 1'b1;
        if (Tx_vld) state_nx = SHIFT;
      end
      SHIFT: begin
        if (last_bit) state_nx = (PARITY_EN != 0) ? PAR : WRITE;
      end
      PAR: begin
        state_nx = par_ok ? WRITE : IDLE;
      end
      WRITE: begin
        write    = 1'b1;
        state_nx = last_adr ? FINISH : INC;
      end
      INC: begin
        inc      = 1'b1;
        state_nx = IDLE;
      end
      FINISH: begin
        Rx_finish = 1'b1;
        if (restart) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      adr     <= '0;
      wdata   <= '0;
      bcnt    <= '0;
      par_err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (Tx_vld) bcnt <= '0;
        SHIFT: begin
          wdata <= {Tx_data, wdata[DATA_W-1:1]};
          bcnt  <= bcnt + 1'b1;
        end
        // A bad word leaves adr alone so the sender can retry the same slot.
        PAR: if (!par_ok) par_err <= 1'b1;
        INC: adr <= adr + 1'b1;
        FINISH: begin
          if (restart) begin
            adr     <= '0;
            par_err <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
